// File: rtl/dffrnq_rst_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : dffrnq_rst_seq_if
//  Brief    : Soft-reset handshake and per-domain RN bus of the reset sequencer.
//  Revision : 1.0
// ============================================================================
interface dffrnq_rst_seq_if #(
    parameter int N_DOM = 4,
    parameter int GAP_W = 4
);
    logic [GAP_W-1:0] gap;
    logic             srst_req;
    logic             srst_ack;
    logic [N_DOM-1:0] rn_out;
    logic             done;

    // master: local controller and RN consumers; slave: the sequencer
    modport master (
        output gap,
        output srst_req,
        input  srst_ack,
        input  rn_out,
        input  done
    );

    modport slave (
        input  gap,
        input  srst_req,
        output srst_ack,
        output rn_out,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/dffrnq_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dffrnq_rst_seq
//  Brief    : Async-assert / sync-release sequencer for RN domains, with gap
//             control and four-phase soft-reset handshake.
//  Revision : 1.0
// ============================================================================
module dffrnq_rst_seq #(
    parameter int N_DOM       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_W       = 4,
    parameter int HOLD_CYC    = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dffrnq_rst_seq_if.slave    bus
);

    localparam int c_HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int c_CNT_W  = (GAP_W > c_HOLD_W) ? GAP_W : c_HOLD_W;
    localparam int c_IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_DOM - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_REL  = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [N_DOM-1:0]       r_rn_out;
    logic                   r_done;
    logic                   r_ack;

    logic [c_CNT_W-1:0]     w_gap_ext;
    logic [c_CNT_W-1:0]     w_first_load;

    assign w_gap_ext    = c_CNT_W'(bus.gap);
    // With a single domain, bit 0 is also the last release: no gap follows it.
    assign w_first_load = (c_LAST_IDX == '0) ? '0 : w_gap_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_SYNC;
            r_sync   <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rn_out <= '0;
            r_done   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            case (r_state)
                ST_SYNC: begin
                    // Release bit 0 on the edge that sees the synchronizer output high.
                    if (r_sync[SYNC_STAGES-1]) begin
                        r_rn_out <= N_DOM'(1);
                        r_cnt    <= w_first_load;
                        r_idx    <= c_IDX_W'(1);
                        r_state  <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else if (r_rn_out[N_DOM-1]) begin
                        r_done  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_rn_out[r_idx] <= 1'b1;
                        r_cnt           <= (r_idx == c_LAST_IDX) ? '0 : w_gap_ext;
                        r_idx           <= r_idx + c_IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.srst_req) begin
                        r_rn_out <= '0;
                        r_done   <= 1'b0;
                        r_cnt    <= c_HOLD_LOAD;
                        r_state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Request withdrawn: drop ACK and release bit 0 on the same edge.
                    if (!bus.srst_req) begin
                        r_ack    <= 1'b0;
                        r_rn_out <= N_DOM'(1);
                        r_cnt    <= w_first_load;
                        r_idx    <= c_IDX_W'(1);
                        r_state  <= ST_REL;
                    end
                end
                default: begin
                    r_state <= ST_SYNC;
                end
            endcase
        end
    end

    assign bus.rn_out   = r_rn_out;
    assign bus.done     = r_done;
    assign bus.srst_ack = r_ack;

endmodule
`default_nettype wire
